// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
// One operand bit per cycle (shift-add multiply, restoring divide) on
// operand magnitudes; sign correction is applied in a single FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             hilo_select,
    output logic             busy,
    output logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic             w_accept;
    logic             w_step;
    logic             w_finish;

    logic [CW-1:0]    r_cnt;

    // Operation context captured at the accepting edge
    logic             r_is_div;
    logic             r_neg_main;
    logic             r_neg_rem;
    logic             r_b_zero;
    logic [WIDTH-1:0] r_a_raw;
    logic [WIDTH-1:0] r_b_mag;

    // Working accumulator: {product high, multiplier/product low} for
    // multiply, {partial remainder, dividend/quotient} for divide
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;
    logic             r_ready;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_trial;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control decode; start is only honoured in IDLE
    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = CALC;
                end
            end
            CALC: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                busy     = 1'b1;
                w_finish = 1'b1;
                w_next   = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Iteration counter for the CALC phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Operand sign analysis and magnitude conversion at acceptance
    always_comb begin
        w_signed = op[0];
        w_a_neg  = w_signed & data_a[WIDTH-1];
        w_b_neg  = w_signed & data_b[WIDTH-1];
        w_a_mag  = w_a_neg ? -data_a : data_a;
        w_b_mag  = w_b_neg ? -data_b : data_b;
    end

    // Latch operation context so later input changes cannot disturb it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_b_zero   <= 1'b0;
            r_a_raw    <= '0;
            r_b_mag    <= '0;
        end else if (w_accept) begin
            r_is_div   <= op[1];
            r_neg_main <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_b_zero   <= (data_b == '0);
            r_a_raw    <= data_a;
            r_b_mag    <= w_b_mag;
        end
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        w_addend    = r_acc_lo[0] ? r_b_mag : '0;
        w_mul_sum   = {1'b0, r_acc_hi} + {1'b0, w_addend};
        // Shifted partial remainder is below 2*divisor, so WIDTH+1 bits
        // suffice and the top bit doubles as the borrow flag.
        w_div_trial = {r_acc_hi, r_acc_lo[WIDTH-1]} - {1'b0, r_b_mag};
        w_div_ok    = ~w_div_trial[WIDTH];
        if (r_is_div) begin
            w_step_hi = w_div_ok ? w_div_trial[WIDTH-1:0]
                                 : {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
            w_step_lo = {r_acc_lo[WIDTH-2:0], w_div_ok};
        end else begin
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
        end
    end

    // Accumulator: loaded with the first operand magnitude, then iterated
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc_hi <= '0;
            r_acc_lo <= '0;
        end else if (w_accept) begin
            r_acc_hi <= '0;
            r_acc_lo <= w_a_mag;
        end else if (w_step) begin
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
        end
    end

    // Sign correction and divide-by-zero substitution for the final result
    always_comb begin
        w_prod     = {r_acc_hi, r_acc_lo};
        w_prod_neg = -w_prod;
        w_fix_hi   = r_acc_hi;
        w_fix_lo   = r_acc_lo;
        if (r_is_div) begin
            if (r_b_zero) begin
                w_fix_lo = '1;
                w_fix_hi = r_a_raw;
            end else begin
                w_fix_lo = r_neg_main ? -r_acc_lo : r_acc_lo;
                w_fix_hi = r_neg_rem  ? -r_acc_hi : r_acc_hi;
            end
        end else if (r_neg_main) begin
            w_fix_hi = w_prod_neg[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod_neg[WIDTH-1:0];
        end
    end

    // HI/LO and divide-by-zero flag update only on completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_dbz <= 1'b0;
        end else if (w_finish) begin
            r_hi  <= w_fix_hi;
            r_lo  <= w_fix_lo;
            r_dbz <= r_is_div & r_b_zero;
        end
    end

    // One-cycle completion pulse following the HI/LO load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_finish;
        end
    end

    assign result       = hilo_select ? r_hi : r_lo;
    assign result_ready = r_ready;
    assign div_by_zero  = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: cycle-level behavioural model with a
// per-cycle compare process, plus directed vectors with literal results.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;

    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hsel;
    logic        busy, rr, dbz;
    logic [31:0] result;

    logic        s8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        h8;
    logic        busy8, rr8, dbz8;
    logic [7:0]  result8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .data_a(a), .data_b(b), .hilo_select(hsel),
        .busy(busy), .result_ready(rr), .result(result), .div_by_zero(dbz)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .op(op8),
        .data_a(a8), .data_b(b8), .hilo_select(h8),
        .busy(busy8), .result_ready(rr8), .result(result8), .div_by_zero(dbz8)
    );

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: returns {div_by_zero, HI, LO} for a w-bit unit
    function automatic logic [64:0] model(input int w, input logic [1:0] mop,
                                          input logic [31:0] ma, input logic [31:0] mb);
        logic [63:0] mask, up;
        longint      sa, sb, q, r;
        logic [31:0] hi, lo;
        logic        dz;
        mask = (64'd1 << w) - 64'd1;
        sa = ma[w-1] ? longint'(ma) - (longint'(1) << w) : longint'(ma);
        sb = mb[w-1] ? longint'(mb) - (longint'(1) << w) : longint'(mb);
        hi = '0; lo = '0; dz = 1'b0; up = '0;
        case (mop)
            2'd0: begin
                up = {32'd0, ma} * {32'd0, mb};
                lo = 32'(up & mask);
                hi = 32'((up >> w) & mask);
            end
            2'd1: begin
                up = 64'(sa * sb);
                lo = 32'(up & mask);
                hi = 32'((up >> w) & mask);
            end
            default: begin
                if (mb == 32'd0) begin
                    lo = 32'(mask);
                    hi = ma;
                    dz = 1'b1;
                end else if (mop == 2'd2) begin
                    lo = ma / mb;
                    hi = ma % mb;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = 32'(64'(q) & mask);
                    hi = 32'(64'(r) & mask);
                end
            end
        endcase
        return {dz, hi, lo};
    endfunction

    // Cycle-level model of the 32-bit unit: a countdown of WIDTH+1 cycles
    int          m_cnt = 0;
    logic [64:0] m_pend = '0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dbz = 1'b0, m_ready = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt   <= 0;
            m_hi    <= '0;
            m_lo    <= '0;
            m_dbz   <= 1'b0;
            m_ready <= 1'b0;
        end else begin
            m_ready <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_dbz   <= m_pend[64];
                    m_hi    <= m_pend[63:32];
                    m_lo    <= m_pend[31:0];
                    m_ready <= 1'b1;
                end
            end else if (start) begin
                m_pend <= model(32, op, a, b);
                m_cnt  <= 33;
            end
        end
    end

    // Per-cycle comparison of the 32-bit unit against the model
    always @(negedge clk) begin
        chk("busy", 65'(busy), 65'(m_cnt != 0));
        chk("ready", 65'(rr), 65'(m_ready));
        chk("result", 65'(result), 65'(hsel ? m_hi : m_lo));
        chk("dbz", 65'(dbz), 65'(m_dbz));
    end

    task automatic pulse32(input bit sync, input logic [1:0] o,
                           input logic [31:0] x, input logic [31:0] y);
        if (sync) begin
            @(posedge clk); #1;
        end
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = ~x; b = y ^ 32'h5A5A_1234; op = ~o;
    endtask

    task automatic wait32(output int n, output int bc);
        n = 0; bc = 0;
        while (!rr && n < 200) begin
            if (busy) bc++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic res32(input string name, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edz);
        hsel = 1'b0; #1;
        chk({name, "_lo"}, 65'(result), 65'(elo));
        hsel = 1'b1; #1;
        chk({name, "_hi"}, 65'(result), 65'(ehi));
        chk({name, "_dbz"}, 65'(dbz), 65'(edz));
        hsel = 1'b0;
    endtask

    task automatic run32(input string name, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edz);
        int n, bc;
        chk({name, "_model"}, model(32, o, x, y), {edz, ehi, elo});
        pulse32(1'b1, o, x, y);
        wait32(n, bc);
        chk({name, "_latency"}, 65'(n), 65'd33);
        chk({name, "_busycycles"}, 65'(bc), 65'd33);
        res32(name, ehi, elo, edz);
    endtask

    task automatic run8(input string name, input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] ehi, input logic [7:0] elo,
                        input logic edz);
        int n;
        logic [64:0] m;
        m = model(8, o, {24'd0, x}, {24'd0, y});
        chk({name, "_model"}, m, {edz, 24'd0, ehi, 24'd0, elo});
        @(posedge clk); #1;
        s8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(posedge clk); #1;
        s8 = 1'b0; a8 = ~x; b8 = ~y;
        n = 0;
        while (!rr8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, 65'(n), 65'd9);
        h8 = 1'b0; #1;
        chk({name, "_lo"}, 65'(result8), 65'(elo));
        h8 = 1'b1; #1;
        chk({name, "_hi"}, 65'(result8), 65'(ehi));
        chk({name, "_dbz"}, 65'(dbz8), 65'(edz));
        h8 = 1'b0;
    endtask

    initial begin
        int n, bc, seen;
        rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; hsel = 1'b0;
        s8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; h8 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 65'(busy), 65'd0);
        chk("reset_lo", 65'(result), 65'd0);
        hsel = 1'b1; #1;
        chk("reset_hi", 65'(result), 65'd0);
        hsel = 1'b0;
        rst = 1'b1;

        run32("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run32("mult_m3x7", 2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run32("div_m7d2", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run32("divu_5d0", 2'd2, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        run32("div_m9d0", 2'd3, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
        run32("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run32("div_7dm2", 2'd3, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run32("mult_minsq", 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run32("divu_big", 2'd2, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);

        // Start while busy must be ignored
        pulse32(1'b1, 2'd0, 32'd1000, 32'd1000);
        repeat (5) begin
            @(posedge clk); #1;
        end
        start = 1'b1; op = 2'd2; a = 32'd9; b = 32'd3;
        repeat (3) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait32(n, bc);
        chk("ignore_latency", 65'(n), 65'd25);
        res32("ignore", 32'd0, 32'h000F_4240, 1'b0);

        // Start in the result_ready cycle is accepted
        pulse32(1'b1, 2'd2, 32'd100, 32'd7);
        wait32(n, bc);
        chk("b2b_first_latency", 65'(n), 65'd33);
        res32("b2b_first", 32'd2, 32'd14, 1'b0);
        pulse32(1'b0, 2'd1, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
        wait32(n, bc);
        chk("b2b_second_latency", 65'(n), 65'd33);
        res32("b2b_second", 32'd0, 32'd30, 1'b0);

        // 8-bit instance
        run8("w8_div_ovf", 2'd3, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
        run8("w8_divu", 2'd2, 8'hFF, 8'h03, 8'h00, 8'h55, 1'b0);
        run8("w8_mult", 2'd1, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0);
        run8("w8_div_m7d2", 2'd3, 8'hF9, 8'h02, 8'hFF, 8'hFD, 1'b0);

        // Reset in the middle of an operation
        pulse32(1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b0; #1;
        chk("abort_busy", 65'(busy), 65'd0);
        chk("abort_ready", 65'(rr), 65'd0);
        chk("abort_lo", 65'(result), 65'd0);
        hsel = 1'b1; #1;
        chk("abort_hi", 65'(result), 65'd0);
        hsel = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rr) seen++;
        end
        chk("abort_no_pulse", 65'(seen), 65'd0);
        rst = 1'b1;
        pulse32(1'b0, 2'd0, 32'd6, 32'd7);
        wait32(n, bc);
        chk("after_rst_latency", 65'(n), 65'd33);
        res32("after_rst", 32'd0, 32'd42, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
